// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand-select codes and FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Bubble counter only needs to hold LOAD_LAT-1 for LOAD_LAT up to 7
  localparam int unsigned BCNT_W = 3;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_select.sv
// One EX operand's forwarding select: MEM result beats WB result, register 0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_write_addr,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_addr,
  output logic [1:0]        fwd_sel_c
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_reg_write && (mem_write_addr != '0) && (mem_write_addr == src_addr);
  assign w_wb_hit  = wb_reg_write && (wb_write_addr != '0) && (wb_write_addr == src_addr);

  always_comb begin
    fwd_sel_c = FWD_REG;
    if (w_mem_hit) begin
      fwd_sel_c = FWD_MEM;
    end else if (w_wb_hit) begin
      fwd_sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: operand forwarding, load-use bubble sequencing,
// memory-wait freeze and saturating stall/forward statistics.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_write_addr,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_write_addr,
  input  logic              mem_access,
  input  logic              mem_ready,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_addr,
  input  logic              clr_stats,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_flush,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  fwd_events
);

  localparam logic [BCNT_W-1:0] BUBBLES_AFTER = BCNT_W'(LOAD_LAT - 1);

  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic              w_freeze;
  logic              w_hazard;
  logic              w_pc;
  logic              w_ifid;
  logic              w_flush;
  logic              w_stall_inc;
  logic              w_fwd_inc;
  state_e            r_state;
  state_e            w_state_nxt;
  logic [BCNT_W-1:0] r_bcnt;
  logic [BCNT_W-1:0] w_bcnt_nxt;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_fwd_events;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src_addr       (ex_rs),
    .mem_reg_write  (mem_reg_write),
    .mem_write_addr (mem_write_addr),
    .wb_reg_write   (wb_reg_write),
    .wb_write_addr  (wb_write_addr),
    .fwd_sel_c      (w_fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src_addr       (ex_rt),
    .mem_reg_write  (mem_reg_write),
    .mem_write_addr (mem_write_addr),
    .wb_reg_write   (wb_reg_write),
    .wb_write_addr  (wb_write_addr),
    .fwd_sel_c      (w_fwd_b)
  );

  assign w_freeze = mem_access && !mem_ready;
  assign w_hazard = ex_mem_read && (ex_write_addr != '0) &&
                    ((id_uses_rs && (ex_write_addr == id_rs)) ||
                     (id_uses_rt && (ex_write_addr == id_rt)));

  // Next-state and pipeline controls; a freeze holds everything and suppresses the bubble
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_pc        = 1'b1;
    w_ifid      = 1'b1;
    w_flush     = 1'b0;
    if (w_freeze) begin
      w_pc   = 1'b0;
      w_ifid = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard) begin
            w_pc    = 1'b0;
            w_ifid  = 1'b0;
            w_flush = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = LU_STALL;
              w_bcnt_nxt  = BUBBLES_AFTER;
            end
          end
        end
        LU_STALL: begin
          w_pc    = 1'b0;
          w_ifid  = 1'b0;
          w_flush = 1'b1;
          if (r_bcnt == BCNT_W'(1)) begin
            w_state_nxt = RUN;
            w_bcnt_nxt  = '0;
          end else begin
            w_bcnt_nxt = r_bcnt - BCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_bcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Controls read as their reset values for as long as rst_n is low
  assign forward_a   = rst_n ? w_fwd_a : FWD_REG;
  assign forward_b   = rst_n ? w_fwd_b : FWD_REG;
  assign pc_write    = rst_n & w_pc;
  assign if_id_write = rst_n & w_ifid;
  assign id_ex_flush = rst_n & w_flush;
  assign pipe_freeze = rst_n & w_freeze;

  assign w_stall_inc = !w_pc;
  assign w_fwd_inc   = !w_freeze && ((w_fwd_a != FWD_REG) || (w_fwd_b != FWD_REG));

  // Saturating statistics; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_fwd_events   <= '0;
    end else begin
      if (clr_stats) begin
        r_stall_cycles <= '0;
      end else if (w_stall_inc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (clr_stats) begin
        r_fwd_events <= '0;
      end else if (w_fwd_inc && (r_fwd_events != '1)) begin
        r_fwd_events <= r_fwd_events + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign fwd_events   = r_fwd_events;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three configurations share one stimulus stream and
// are checked against a bubbles-owed reference model plus directed expectations.
`timescale 1ns/1ps
module tb_hazard_forward_unit;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_addr, mem_write_addr, wb_write_addr;
  logic       id_uses_rs, id_uses_rt, ex_mem_read, mem_reg_write, mem_access, mem_ready;
  logic       wb_reg_write, clr_stats;

  logic [1:0] fa [N];
  logic [1:0] fb [N];
  logic       pcw [N];
  logic       ifw [N];
  logic       fl [N];
  logic       fz [N];
  logic [15:0] sc0, sc1, fe0, fe1;
  logic [3:0]  sc2, fe2;

  int total = 0;
  int bad = 0;
  int m_rem [N] = '{0, 0, 0};
  int m_sc [N]  = '{0, 0, 0};
  int m_fe [N]  = '{0, 0, 0};

  always #5 clk = ~clk;

  hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_write_addr(ex_write_addr), .mem_reg_write(mem_reg_write), .mem_write_addr(mem_write_addr),
    .mem_access(mem_access), .mem_ready(mem_ready), .wb_reg_write(wb_reg_write),
    .wb_write_addr(wb_write_addr), .clr_stats(clr_stats), .forward_a(fa[0]), .forward_b(fb[0]),
    .pc_write(pcw[0]), .if_id_write(ifw[0]), .id_ex_flush(fl[0]), .pipe_freeze(fz[0]),
    .stall_cycles(sc0), .fwd_events(fe0));

  hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_write_addr(ex_write_addr), .mem_reg_write(mem_reg_write), .mem_write_addr(mem_write_addr),
    .mem_access(mem_access), .mem_ready(mem_ready), .wb_reg_write(wb_reg_write),
    .wb_write_addr(wb_write_addr), .clr_stats(clr_stats), .forward_a(fa[1]), .forward_b(fb[1]),
    .pc_write(pcw[1]), .if_id_write(ifw[1]), .id_ex_flush(fl[1]), .pipe_freeze(fz[1]),
    .stall_cycles(sc1), .fwd_events(fe1));

  hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_write_addr(ex_write_addr), .mem_reg_write(mem_reg_write), .mem_write_addr(mem_write_addr),
    .mem_access(mem_access), .mem_ready(mem_ready), .wb_reg_write(wb_reg_write),
    .wb_write_addr(wb_write_addr), .clr_stats(clr_stats), .forward_a(fa[2]), .forward_b(fb[2]),
    .pc_write(pcw[2]), .if_id_write(ifw[2]), .id_ex_flush(fl[2]), .pipe_freeze(fz[2]),
    .stall_cycles(sc2), .fwd_events(fe2));

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 2;
  endfunction

  function automatic int max_of(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic int act_sc(input int i);
    return (i == 0) ? int'(sc0) : (i == 1) ? int'(sc1) : int'(sc2);
  endfunction

  function automatic int act_fe(input int i);
    return (i == 0) ? int'(fe0) : (i == 1) ? int'(fe1) : int'(fe2);
  endfunction

  function automatic logic f_freeze();
    return mem_access && !mem_ready;
  endfunction

  function automatic logic f_hazard();
    return ex_mem_read && (ex_write_addr != 0) &&
           ((id_uses_rs && ex_write_addr == id_rs) || (id_uses_rt && ex_write_addr == id_rt));
  endfunction

  function automatic logic [1:0] f_fwd(input logic [4:0] src);
    if (!rst_n) return 2'b00;
    if (mem_reg_write && mem_write_addr != 0 && mem_write_addr == src) return 2'b10;
    if (wb_reg_write && wb_write_addr != 0 && wb_write_addr == src) return 2'b01;
    return 2'b00;
  endfunction

  // A hazard owes LOAD_LAT bubbles; only unfrozen cycles pay them off
  function automatic logic e_pc(input int i);
    return rst_n && !f_freeze() && m_rem[i] == 0 && !f_hazard();
  endfunction

  function automatic logic e_flush(input int i);
    return rst_n && !f_freeze() && (m_rem[i] > 0 || f_hazard());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_rem[i] <= 0;
        m_sc[i]  <= 0;
        m_fe[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!f_freeze()) begin
          if (m_rem[i] > 0) m_rem[i] <= m_rem[i] - 1;
          else if (f_hazard()) m_rem[i] <= lat_of(i) - 1;
        end
        if (clr_stats) m_sc[i] <= 0;
        else if (!e_pc(i) && m_sc[i] < max_of(i)) m_sc[i] <= m_sc[i] + 1;
        if (clr_stats) m_fe[i] <= 0;
        else if (!f_freeze() && (f_fwd(ex_rs) != 0 || f_fwd(ex_rt) != 0) && m_fe[i] < max_of(i))
          m_fe[i] <= m_fe[i] + 1;
      end
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_mem_read = 0; ex_write_addr = 0; mem_reg_write = 0; mem_write_addr = 0;
    mem_access = 0; mem_ready = 1; wb_reg_write = 0; wb_write_addr = 0; clr_stats = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hazard();
    ex_mem_read = 1; ex_write_addr = 3; id_rs = 3; id_uses_rs = 1;
  endtask

  task automatic clear_stats();
    clr_stats = 1;
    tick();
    clr_stats = 0;
  endtask

  task automatic test_reset();
    rst_n = 1;
    idle();
    #1 rst_n = 0;
    mem_access = 1; mem_ready = 0; ex_rs = 5; mem_write_addr = 5; mem_reg_write = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (pcw[i] !== 1'b0) begin bad++; $display("FAIL reset_pc inst%0d got=%b exp=0", i, pcw[i]); end
      total++; if (ifw[i] !== 1'b0) begin bad++; $display("FAIL reset_ifid inst%0d got=%b exp=0", i, ifw[i]); end
      total++; if (fl[i] !== 1'b0) begin bad++; $display("FAIL reset_flush inst%0d got=%b exp=0", i, fl[i]); end
      total++; if (fz[i] !== 1'b0) begin bad++; $display("FAIL reset_freeze inst%0d got=%b exp=0", i, fz[i]); end
      total++; if (fa[i] !== 2'b00) begin bad++; $display("FAIL reset_fwd_a inst%0d got=%b exp=00", i, fa[i]); end
      total++; if (act_sc(i) != 0 || act_fe(i) != 0) begin
        bad++; $display("FAIL reset_stats inst%0d got sc=%0d fe=%0d exp=0", i, act_sc(i), act_fe(i));
      end
    end
    idle();
    #2 rst_n = 1;
    tick();
  endtask

  task automatic test_forward();
    logic [1:0] ef;
    idle();
    clear_stats();
    for (int p = 0; p < 3; p++) begin
      ex_rt = 7; mem_write_addr = 5; wb_write_addr = 5; wb_reg_write = 1;
      mem_reg_write = (p != 1);
      ex_rs = (p == 2) ? 5'd0 : 5'd5;
      ef = (p == 0) ? 2'b10 : (p == 1) ? 2'b01 : 2'b00;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        total++; if (fa[i] !== ef) begin bad++; $display("FAIL fwd_a_p%0d inst%0d got=%b exp=%b", p, i, fa[i], ef); end
        total++; if (fb[i] !== 2'b00) begin bad++; $display("FAIL fwd_b_p%0d inst%0d got=%b exp=00", p, i, fb[i]); end
      end
      tick();
    end
    idle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (act_fe(i) != 2) begin bad++; $display("FAIL fwd_events inst%0d got=%0d exp=2", i, act_fe(i)); end
    end
    tick();
  endtask

  task automatic test_load_use();
    logic ep;
    idle();
    clear_stats();
    for (int j = 0; j < 5; j++) begin
      idle();
      if (j == 0) set_hazard();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ep = (j >= lat_of(i));
        total++; if (pcw[i] !== ep) begin bad++; $display("FAIL lu_pc_c%0d inst%0d got=%b exp=%b", j, i, pcw[i], ep); end
        total++; if (ifw[i] !== ep) begin bad++; $display("FAIL lu_ifid_c%0d inst%0d got=%b exp=%b", j, i, ifw[i], ep); end
        total++; if (fl[i] !== !ep) begin bad++; $display("FAIL lu_flush_c%0d inst%0d got=%b exp=%b", j, i, fl[i], !ep); end
      end
      tick();
    end
    idle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (act_sc(i) != lat_of(i)) begin bad++; $display("FAIL lu_stall_cycles inst%0d got=%0d exp=%0d", i, act_sc(i), lat_of(i)); end
    end
    tick();
    set_hazard(); id_uses_rs = 0; id_uses_rt = 1; id_rt = 4;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (pcw[i] !== 1'b1 || fl[i] !== 1'b0) begin
        bad++; $display("FAIL lu_unused_src inst%0d got pc=%b flush=%b exp pc=1 flush=0", i, pcw[i], fl[i]);
      end
    end
    tick();
    idle();
  endtask

  task automatic test_freeze_in_stall();
    logic frz, ef, ep;
    idle();
    clear_stats();
    for (int j = 0; j < 7; j++) begin
      idle();
      frz = (j == 1 || j == 2);
      if (j == 0) set_hazard();
      if (frz) begin mem_access = 1; mem_ready = 0; end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ef = !frz && (j == 0 || (j >= 3 && j < 2 + lat_of(i)));
        ep = !(j < 2 + lat_of(i));
        total++; if (fz[i] !== frz) begin bad++; $display("FAIL fz_freeze_c%0d inst%0d got=%b exp=%b", j, i, fz[i], frz); end
        total++; if (fl[i] !== ef) begin bad++; $display("FAIL fz_flush_c%0d inst%0d got=%b exp=%b", j, i, fl[i], ef); end
        total++; if (pcw[i] !== ep) begin bad++; $display("FAIL fz_pc_c%0d inst%0d got=%b exp=%b", j, i, pcw[i], ep); end
      end
      tick();
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (act_sc(i) != lat_of(i) + 2) begin
        bad++; $display("FAIL fz_stall_cycles inst%0d got=%0d exp=%0d", i, act_sc(i), lat_of(i) + 2);
      end
    end
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    clear_stats();
    set_hazard();
    tick();
    idle();
    @(negedge clk);
    total++; if (fl[1] !== 1'b1) begin bad++; $display("FAIL ar_in_stall got flush=%b exp=1", fl[1]); end
    #1 rst_n = 0;
    mem_access = 1; mem_ready = 0; ex_rs = 6; wb_write_addr = 6; wb_reg_write = 1;
    #1;
    for (int i = 0; i < N; i++) begin
      total++; if (pcw[i] !== 1'b0 || ifw[i] !== 1'b0 || fl[i] !== 1'b0 || fz[i] !== 1'b0) begin
        bad++; $display("FAIL ar_ctrl inst%0d got pc=%b ifid=%b flush=%b freeze=%b exp all 0", i, pcw[i], ifw[i], fl[i], fz[i]);
      end
      total++; if (fa[i] !== 2'b00) begin bad++; $display("FAIL ar_fwd inst%0d got=%b exp=00", i, fa[i]); end
      total++; if (act_sc(i) != 0 || act_fe(i) != 0) begin
        bad++; $display("FAIL ar_stats inst%0d got sc=%0d fe=%0d exp=0", i, act_sc(i), act_fe(i));
      end
    end
    idle();
    #1 rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (pcw[i] !== 1'b1 || fl[i] !== 1'b0) begin
        bad++; $display("FAIL ar_restart inst%0d got pc=%b flush=%b exp pc=1 flush=0", i, pcw[i], fl[i]);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    int es;
    idle();
    clear_stats();
    mem_access = 1; mem_ready = 0;
    repeat (20) tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      es = (i == 2) ? 15 : 20;
      total++; if (act_sc(i) != es) begin bad++; $display("FAIL sat_stall inst%0d got=%0d exp=%0d", i, act_sc(i), es); end
    end
    clr_stats = 1;
    tick();
    clr_stats = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (act_sc(i) != 0) begin bad++; $display("FAIL sat_clear inst%0d got=%0d exp=0", i, act_sc(i)); end
    end
    tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      total++; if (act_sc(i) != 1) begin bad++; $display("FAIL sat_after_clear inst%0d got=%0d exp=1", i, act_sc(i)); end
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom); ex_write_addr = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom); mem_write_addr = 5'($urandom_range(0, 3));
      wb_reg_write = 1'($urandom); wb_write_addr = 5'($urandom_range(0, 3));
      mem_access = 1'($urandom); mem_ready = ($urandom_range(0, 2) != 0);
      clr_stats = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        total++; if (fa[i] !== f_fwd(ex_rs)) begin bad++; $display("FAIL rnd_fwd_a n%0d inst%0d got=%b exp=%b", n, i, fa[i], f_fwd(ex_rs)); end
        total++; if (fb[i] !== f_fwd(ex_rt)) begin bad++; $display("FAIL rnd_fwd_b n%0d inst%0d got=%b exp=%b", n, i, fb[i], f_fwd(ex_rt)); end
        total++; if (pcw[i] !== e_pc(i)) begin bad++; $display("FAIL rnd_pc n%0d inst%0d got=%b exp=%b", n, i, pcw[i], e_pc(i)); end
        total++; if (ifw[i] !== e_pc(i)) begin bad++; $display("FAIL rnd_ifid n%0d inst%0d got=%b exp=%b", n, i, ifw[i], e_pc(i)); end
        total++; if (fl[i] !== e_flush(i)) begin bad++; $display("FAIL rnd_flush n%0d inst%0d got=%b exp=%b", n, i, fl[i], e_flush(i)); end
        total++; if (fz[i] !== f_freeze()) begin bad++; $display("FAIL rnd_freeze n%0d inst%0d got=%b exp=%b", n, i, fz[i], f_freeze()); end
        total++; if (act_sc(i) != m_sc[i]) begin bad++; $display("FAIL rnd_stall n%0d inst%0d got=%0d exp=%0d", n, i, act_sc(i), m_sc[i]); end
        total++; if (act_fe(i) != m_fe[i]) begin bad++; $display("FAIL rnd_fwdev n%0d inst%0d got=%0d exp=%0d", n, i, act_fe(i), m_fe[i]); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_freeze_in_stall();
    test_async_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
